// File: rtl/seq_det_pkg.sv
// Shared types and constants for the 1010 serial pattern detector.
// Overlap behaviour is selected in seq_detector_1010 by the SEQDET_OVERLAP_EN macro.
package seq_det_pkg;

    typedef enum logic [1:0] {
        M_S0,
        M_S1,
        M_S2,
        M_S3
    } mealy_state_t;

    typedef enum logic [2:0] {
        P_S0,
        P_S1,
        P_S2,
        P_S3,
        P_DET
    } moore_state_t;

    // First-received bit is PATTERN[3].
    localparam logic [3:0] PATTERN = 4'b1010;

    typedef struct packed {
        mealy_state_t mealy;
        moore_state_t moore;
    } seq_det_dbg_t;

endpackage

// File: rtl/seq_detector_1010.sv
// Detects 1010 on a serial input with a same-cycle Mealy flag and a registered Moore flag.
// Define SEQDET_OVERLAP_EN to let the trailing "10" of a match start the next one.
module seq_detector_1010
    import seq_det_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         din,
    output logic         mealy_flag,
    output logic         moore_flag,
    output seq_det_dbg_t dbg
);

`ifdef SEQDET_OVERLAP_EN
    localparam mealy_state_t M_AFTER_MATCH = M_S2;
    localparam moore_state_t P_DET_ON_ONE  = P_S3;
`else
    localparam mealy_state_t M_AFTER_MATCH = M_S0;
    localparam moore_state_t P_DET_ON_ONE  = P_S1;
`endif

    mealy_state_t mealy_q, mealy_d;
    moore_state_t moore_q, moore_d;
    logic         moore_flag_q;

    // Mealy FSM: flag is decoded from state and the live input bit.
    always_comb begin
        mealy_d    = M_S0;
        mealy_flag = 1'b0;
        case (mealy_q)
            M_S0: mealy_d = (din == PATTERN[3]) ? M_S1 : M_S0;
            M_S1: mealy_d = (din == PATTERN[2]) ? M_S2 : M_S1;
            M_S2: mealy_d = (din == PATTERN[1]) ? M_S3 : M_S0;
            M_S3: begin
                if (din == PATTERN[0]) begin
                    mealy_flag = 1'b1;
                    mealy_d    = M_AFTER_MATCH;
                end else begin
                    mealy_d    = M_S1;
                end
            end
            default: mealy_d = M_S0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mealy_q <= M_S0;
        end else begin
            mealy_q <= mealy_d;
        end
    end

    // Moore FSM: unused encodings fall back to P_S0.
    always_comb begin
        moore_d = P_S0;
        case (moore_q)
            P_S0:    moore_d = (din == PATTERN[3]) ? P_S1 : P_S0;
            P_S1:    moore_d = (din == PATTERN[2]) ? P_S2 : P_S1;
            P_S2:    moore_d = (din == PATTERN[1]) ? P_S3 : P_S0;
            P_S3:    moore_d = (din == PATTERN[0]) ? P_DET : P_S1;
            P_DET:   moore_d = din ? P_DET_ON_ONE : P_S0;
            default: moore_d = P_S0;
        endcase
    end

    // The flag flop always mirrors (moore_q == P_DET) but is driven straight from a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            moore_q      <= P_S0;
            moore_flag_q <= 1'b0;
        end else begin
            moore_q      <= moore_d;
            moore_flag_q <= (moore_d == P_DET);
        end
    end

    assign moore_flag = moore_flag_q;
    assign dbg.mealy  = mealy_q;
    assign dbg.moore  = moore_q;

endmodule

// File: tb/tb_seq_detector_1010.sv
// Randomised and directed bench for seq_detector_1010 against a bit-history reference model.
module tb_seq_detector_1010;
    import seq_det_pkg::*;

`ifdef SEQDET_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         din = 1'b0;
    logic         mealy_flag;
    logic         moore_flag;
    seq_det_dbg_t dbg;

    int checks = 0;
    int errors = 0;

    logic       hist[$];
    logic [0:0] exp_q[$];
    int         last_det;
    int         det_pos[$];
    int         mealy_hits;
    int         moore_hits;
    int         model_hits;

    seq_detector_1010 dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .mealy_flag (mealy_flag),
        .moore_flag (moore_flag),
        .dbg        (dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Match = last three received bits are 1,0,1 and the new bit is 0, all since reset;
    // without overlap the window must start after the final bit of the previous match.
    function automatic logic model_det(input logic b);
        int n;
        n = hist.size();
        if (n < 3) return 1'b0;
        if (!(hist[n-3] == 1'b1 && hist[n-2] == 1'b0 && hist[n-1] == 1'b1 && b == 1'b0))
            return 1'b0;
        return OVL || ((n - 3) > last_det);
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b0;
        din = 1'b0;
        #1;
        check("rst_mealy", {31'd0, mealy_flag}, 32'd0);
        check("rst_moore", {31'd0, moore_flag}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        hist.delete();
        exp_q.delete();
        det_pos.delete();
        last_det   = -100;
        mealy_hits = 0;
        moore_hits = 0;
        model_hits = 0;
    endtask

    task automatic send_bit(input logic b, input string tag);
        logic exp_m;
        logic exp_p;
        @(negedge clk);
        din = b;
        #1;
        exp_m = model_det(b);
        exp_p = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
        check({tag, "_mealy"}, {31'd0, mealy_flag}, {31'd0, exp_m});
        check({tag, "_moore"}, {31'd0, moore_flag}, {31'd0, exp_p});
        if (mealy_flag) begin
            mealy_hits++;
            det_pos.push_back(hist.size() + 1);
        end
        if (moore_flag) moore_hits++;
        if (exp_m) begin
            model_hits++;
            last_det = hist.size();
        end
        hist.push_back(b);
        exp_q.push_back(exp_m);
    endtask

    // Bits go out LSB first; a trailing 1 cannot complete a match but lets the last Moore pulse show.
    task automatic run_seq(input logic [31:0] bits, input int n, input string tag);
        reset_dut();
        for (int i = 0; i < n; i++) send_bit(bits[i], tag);
        send_bit(1'b1, tag);
    endtask

    initial begin
        int exp_pos[$];
        logic [31:0] pat;

        // Reset mid-pattern after 101, then a lone 0 must not detect.
        reset_dut();
        send_bit(1'b1, "pre");
        send_bit(1'b0, "pre");
        send_bit(1'b1, "pre");
        reset_dut();
        send_bit(1'b0, "post_rst");
        send_bit(1'b1, "post_rst");
        check("post_rst_hits", mealy_hits, 32'd0);

        run_seq(32'b0101, 4, "single");
        check("single_hits", mealy_hits, 32'd1);
        check("single_moore_hits", moore_hits, 32'd1);
        check("single_pos", (det_pos.size() > 0) ? det_pos[0] : 0, 32'd4);

        run_seq(32'b010101, 6, "overlap");
        check("overlap_hits", mealy_hits, OVL ? 32'd2 : 32'd1);
        check("overlap_moore_hits", moore_hits, OVL ? 32'd2 : 32'd1);

        run_seq(32'b01011, 5, "prefix11010");
        check("prefix11010_hits", mealy_hits, 32'd1);
        check("prefix11010_pos", (det_pos.size() > 0) ? det_pos[0] : 0, 32'd5);

        run_seq(32'b01001, 5, "prefix10010");
        check("prefix10010_hits", mealy_hits, 32'd0);

        pat = 32'h6AA3_6155;
        run_seq(pat, 32, "long");
        if (OVL) exp_pos = '{4, 6, 8, 10, 25, 27, 29};
        else     exp_pos = '{4, 8, 25, 29};
        check("long_hits", mealy_hits, exp_pos.size());
        check("long_moore_hits", moore_hits, exp_pos.size());
        for (int i = 0; i < exp_pos.size(); i++)
            check("long_pos", (i < det_pos.size()) ? det_pos[i] : 0, exp_pos[i]);

        reset_dut();
        for (int i = 0; i < 10000; i++) send_bit(1'($urandom_range(0, 1)), "rand");
        send_bit(1'b1, "rand");
        check("rand_mealy_hits", mealy_hits, model_hits);
        check("rand_moore_hits", moore_hits, model_hits);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
